// File: rtl/gen_regfile_pkg.sv
// Shared constants and the address-width helper for the generic register file.
package gen_regfile_pkg;

  localparam int GRF_WIDTH = 32;
  localparam int GRF_DEPTH = 16;

  // ceil(log2(n)), never below 1 so a 2-entry file still has a 1-bit index
  function automatic int grf_aw(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/gen_regfile_entry.sv
// One storage word of the register file: synchronous clear to INIT, write enable.
module regfile_entry #(
  parameter int                 WIDTH = 32,
  parameter logic [WIDTH-1:0]   INIT  = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // power-up value matches the clear value so simulation starts defined
  logic [WIDTH-1:0] q_r = INIT;

  always_ff @(posedge clk) begin
    if (clr)     q_r <= INIT;
    else if (en) q_r <= d;
  end

  assign q = q_r;

endmodule

// File: rtl/gen_regfile.sv
// Register file with per-entry busy scoreboard, two async read ports, one write port.
// Optional same-cycle write-to-read forwarding when GEN_REGFILE_BYPASS_EN is defined.
module gen_regfile
  import gen_regfile_pkg::*;
#(
  parameter int          WIDTH   = GRF_WIDTH,
  parameter int          DEPTH   = GRF_DEPTH,
  parameter bit          R0_ZERO = 1'b1,
  parameter logic [31:0] INIT    = 32'h0,
  localparam int         AW      = grf_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic [DEPTH-1:0] busy_vec
);

  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  logic [DEPTH-1:0][WIDTH-1:0] ents;
  logic [DEPTH-1:0]            busy_r = '0;
  logic [DEPTH-1:0]            busy_nxt;

  // storage array; entry 0 collapses to a constant when hardwired
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (R0_ZERO && i == 0) begin : g_zero
      assign ents[i] = '0;
    end else begin : g_reg
      regfile_entry #(
        .WIDTH (WIDTH),
        .INIT  (INIT_W)
      ) u_entry (
        .clk (clk),
        .clr (clr),
        .en  (wr_en && (wr_addr == AW'(i))),
        .d   (wr_data),
        .q   (ents[i])
      );
    end
  end

  // write releases, reservation sets; applied in that order so a
  // same-address reserve in the same cycle wins
  always_comb begin
    busy_nxt = busy_r;
    if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (R0_ZERO) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) busy_r <= '0;
    else     busy_r <= busy_nxt;
  end

  assign busy_vec = busy_r;

`ifdef GEN_REGFILE_BYPASS_EN
  logic fwd_ok;
  logic fwd_busy;

  assign fwd_ok   = wr_en && !clr && !(R0_ZERO && wr_addr == '0);
  assign fwd_busy = rsv_en && (rsv_addr == wr_addr);

  always_comb begin
    rd_data_a = ents[rd_addr_a];
    rd_data_b = ents[rd_addr_b];
    busy_a    = busy_r[rd_addr_a];
    busy_b    = busy_r[rd_addr_b];
    if (fwd_ok && rd_addr_a == wr_addr) begin
      rd_data_a = wr_data;
      busy_a    = fwd_busy;
    end
    if (fwd_ok && rd_addr_b == wr_addr) begin
      rd_data_b = wr_data;
      busy_b    = fwd_busy;
    end
  end
`else
  always_comb begin
    rd_data_a = ents[rd_addr_a];
    rd_data_b = ents[rd_addr_b];
    busy_a    = busy_r[rd_addr_a];
    busy_b    = busy_r[rd_addr_b];
  end
`endif

endmodule
